traffic_demand_monitor: RTL and testbench
=========================================

Name: traffic_demand_monitor

Overview:
Produces the demand and emergency inputs consumed by the intersection light controller, closing the loop between roadside detectors and the light FSM. Counts arrivals per lane (main, left-turn, secondary, pedestrian) from detector pulses, and counts departures while the controller shows that lane green. Derives the relative-demand flags, the absolute-threshold vector and a qualified, held emergency request. Sits between the detector pads and the controller, and reads back the controller's light outputs.

Parameters:
DEP_CYCLES, 4, clk cycles per departure while a lane is green (>=1)
MORE_MARGIN, 2, queue difference required to assert m_more / s_more
ABS_THRESH, 5, per-lane queue level that sets the absolute_num bit
P_THRESH, 3, pedestrian queue level that sets p_more
EMG_QUAL, 3, cycles the synchronized emergency request must stay high before it is accepted
EMG_HOLD, 8, cycles s_emergency stays high after the request drops

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
m_det  in  1  main-road detector, async level; each rising edge is one arrival
l_det  in  1  left-turn detector, async level
s_det  in  1  secondary-road detector, async level
p_btn  in  1  pedestrian push button, async level
emg_req  in  1  emergency-vehicle request, async level
m_LRYG  in  4  controller main lights {L,R,Y,G}; bit0 = main green, bit3 = left arrow
s_RYG  in  3  controller secondary lights {R,Y,G}; bit0 = secondary green
p  in  1  controller pedestrian walk
main_num  out  3  main queue, saturating 0..7
left_num  out  3  left queue
sec_num  out  3  secondary queue
p_num  out  3  pedestrian queue
m_more  out  1  main_num >= sec_num + MORE_MARGIN
s_more  out  1  sec_num >= main_num + MORE_MARGIN
p_more  out  1  p_num >= P_THRESH
l_zero  out  1  left_num == 0
absolute_num  out  3  {main_num>=ABS_THRESH, sec_num>=ABS_THRESH, left_num>=ABS_THRESH}
s_emergency  out  1  qualified emergency

Behaviour:
- Reset: all queues 0; m_more, s_more, p_more, s_emergency = 0; l_zero = 1; absolute_num = 000. Synchronizers, edge registers and timers = 0. Emergency FSM = E_IDLE.
- Detector inputs: 2-FF synchronizer, then rising-edge detect against the previous synchronized value. Pulses shorter than 2 clk cycles are not guaranteed to be seen.
- Arrival latency: count changes on the 3rd rising clk edge at or after the input rises. Flags change 1 cycle after the count.
- Green qualifiers:
  - main green = m_LRYG[0]
  - left green = m_LRYG[3]
  - secondary green = s_RYG[0]
  - pedestrian green = p
  - Lights are already clk-synchronous and are used unsynchronized.
- Departure timer per lane:
  - Cleared while the lane is not green.
  - While green, increments; at DEP_CYCLES-1 it produces a one-cycle tick and wraps to 0.
  - First tick comes DEP_CYCLES cycles after green is first sampled high.
- Queue update per lane, evaluated every cycle:
  - Arrival and no tick: +1, saturating at 7.
  - Tick and no arrival: -1, floored at 0; the tick is consumed even when the queue is 0.
  - Both at once: unchanged.
  - Neither: unchanged.
- Flags: registered. Comparisons use 4-bit unsigned sums, so no wrap. Both m_more and s_more = 0 when neither condition holds.
- Emergency FSM (on synchronized emg_req, r):
  - E_IDLE: s_emergency=0. r=1 -> E_QUAL with qualify counter = 1.
  - E_QUAL: s_emergency=0. r=0 -> E_IDLE. Counter reaching EMG_QUAL -> E_ACTIVE. Otherwise count up.
  - E_ACTIVE: s_emergency=1. r=0 -> E_HOLD with hold counter = 0.
  - E_HOLD: s_emergency=1. r=1 -> E_ACTIVE. Hold counter reaching EMG_HOLD-1 -> E_IDLE. Otherwise count up.
  - s_emergency is a registered Moore output.
- Emergency does not alter the queues.
- Reset asserted mid-operation clears everything immediately; in-flight edges are lost.
- A detector held high counts once; it must fall and rise again to count another arrival.

Decomposition:
- Shared package tdm_pkg holds:
  - light bit indices (M_G_BIT=0, M_L_BIT=3, S_G_BIT=0)
  - queue width QW=3 and QMAX=7
  - the emergency state enum E_IDLE/E_QUAL/E_ACTIVE/E_HOLD
- Sub-module lane_queue_counter (synchronizer, edge detect, departure timer, saturating counter), instantiated 4x.
- Flag logic and the emergency FSM live in the top.

Test Plan:
1. Reset, then 3 m_det pulses (4 cycles high, 4 low), all lights red -> main_num=3; m_more=1 (3>=0+2); s_more=0; l_zero=1; absolute_num=000.
2. Drive s_det 9 pulses -> sec_num saturates at 7, never wraps; absolute_num=010; s_more=1.
3. sec_num=4, then hold s_RYG=001 for 12 cycles -> 3 ticks at cycles 4/8/12; sec_num=1. Green held longer -> floors at 0.
4. s_det edge lands on the same cycle as a departure tick, sec_num=2 -> sec_num stays 2.
5. emg_req high 2 cycles then low -> s_emergency stays 0. emg_req high 10 cycles -> s_emergency rises after sync+3, stays 8 cycles after the drop, then 0. Re-raising during E_HOLD keeps it at 1 continuously.
6. Assert rst mid-count with main_num=5 and s_emergency=1 -> all outputs at reset values in the same cycle; l_zero=1.

Source files
------------

// File: rtl/traffic_demand_monitor_pkg.sv
// Shared definitions for the traffic demand monitor: light bit positions,
// queue sizing and the emergency qualifier state encoding.
package tdm_pkg;

    localparam int M_G_BIT = 0;   // main green in m_LRYG
    localparam int M_L_BIT = 3;   // left arrow in m_LRYG
    localparam int S_G_BIT = 0;   // secondary green in s_RYG

    localparam int            QW   = 3;
    localparam logic [QW-1:0] QMAX = '1;

    typedef enum logic [1:0] {
        E_IDLE,
        E_QUAL,
        E_ACTIVE,
        E_HOLD
    } emg_state_e;

endpackage

// File: rtl/traffic_demand_monitor_lane_queue_counter.sv
// One lane: synchronizes the detector, turns each rising edge into an arrival,
// produces departure ticks while the lane is green, and keeps a saturating
// queue count.
module lane_queue_counter
    import tdm_pkg::*;
#(
    parameter int DEP_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_det,
    input  logic          i_green,
    output logic [QW-1:0] o_q
);

    localparam int            TW    = (DEP_CYCLES > 1) ? $clog2(DEP_CYCLES) : 1;
    localparam logic [TW-1:0] TLAST = TW'(DEP_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_prev;
    logic [TW-1:0] r_tmr;
    logic [QW-1:0] r_q;
    logic          w_arr;
    logic          w_tick;

    // Simultaneous arrival and departure cancel; otherwise step by one and
    // clamp at the ends. A departure on an empty queue is simply dropped.
    function automatic logic [QW-1:0] sat_next(input logic [QW-1:0] q,
                                               input logic          arr,
                                               input logic          dep);
        logic [QW-1:0] n;
        n = q;
        if (arr && !dep && (q != QMAX))
            n = q + 1'b1;
        else if (dep && !arr && (q != '0))
            n = q - 1'b1;
        return n;
    endfunction

    assign w_arr  = r_sync2 & ~r_prev;
    assign w_tick = i_green && (r_tmr == TLAST);
    assign o_q    = r_q;

    // Two-flop synchronizer plus the previous synchronized sample for edge detect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_det;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Departure timer: idle at zero off-green, wraps after the last count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_tmr <= '0;
        else if (!i_green || (r_tmr == TLAST))
            r_tmr <= '0;
        else
            r_tmr <= r_tmr + 1'b1;
    end

    // Queue occupancy update from this cycle's arrival and departure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_q <= '0;
        else
            r_q <= sat_next(r_q, w_arr, w_tick);
    end

endmodule

// File: rtl/traffic_demand_monitor.sv
// Demand front end for the intersection light controller: per-lane queues,
// relative and absolute demand flags, and a qualified, held emergency request.
module traffic_demand_monitor
    import tdm_pkg::*;
#(
    parameter int DEP_CYCLES  = 4,
    parameter int MORE_MARGIN = 2,
    parameter int ABS_THRESH  = 5,
    parameter int P_THRESH    = 3,
    parameter int EMG_QUAL    = 3,
    parameter int EMG_HOLD    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       m_det,
    input  logic       l_det,
    input  logic       s_det,
    input  logic       p_btn,
    input  logic       emg_req,
    input  logic [3:0] m_LRYG,
    input  logic [2:0] s_RYG,
    input  logic       p,
    output logic [2:0] main_num,
    output logic [2:0] left_num,
    output logic [2:0] sec_num,
    output logic [2:0] p_num,
    output logic       m_more,
    output logic       s_more,
    output logic       p_more,
    output logic       l_zero,
    output logic [2:0] absolute_num,
    output logic       s_emergency
);

    localparam int CMAX = (EMG_QUAL > EMG_HOLD) ? EMG_QUAL : EMG_HOLD;
    localparam int CW   = $clog2(CMAX + 1);

    // Lane order throughout: 0 main, 1 left, 2 secondary, 3 pedestrian.
    logic [3:0]    w_det;
    logic [3:0]    w_green;
    logic [QW-1:0] w_q [4];
    logic          w_unused;

    logic          r_m_more;
    logic          r_s_more;
    logic          r_p_more;
    logic          r_l_zero;
    logic [2:0]    r_abs;

    logic          r_emg_s1;
    logic          r_emg_s2;
    emg_state_e    r_state;
    emg_state_e    w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_emg_out;

    // Unsigned compare one bit wider than the queue so a + margin never wraps.
    function automatic logic ge_margin(input logic [QW-1:0] a, input logic [QW-1:0] b);
        return {1'b0, a} >= ({1'b0, b} + (QW+1)'(MORE_MARGIN));
    endfunction

    function automatic logic ge_level(input logic [QW-1:0] a, input int lvl);
        return {1'b0, a} >= (QW+1)'(lvl);
    endfunction

    assign w_det    = {p_btn, s_det, l_det, m_det};
    assign w_green  = {p, s_RYG[S_G_BIT], m_LRYG[M_L_BIT], m_LRYG[M_G_BIT]};
    // Amber/red bits are not needed; they are collected here on purpose.
    assign w_unused = &{1'b0, m_LRYG[2:1], s_RYG[2:1]};

    for (genvar i = 0; i < 4; i++) begin : g_lane
        lane_queue_counter #(
            .DEP_CYCLES(DEP_CYCLES)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .i_det  (w_det[i]),
            .i_green(w_green[i]),
            .o_q    (w_q[i])
        );
    end

    assign main_num     = w_q[0];
    assign left_num     = w_q[1];
    assign sec_num      = w_q[2];
    assign p_num        = w_q[3];
    assign m_more       = r_m_more;
    assign s_more       = r_s_more;
    assign p_more       = r_p_more;
    assign l_zero       = r_l_zero;
    assign absolute_num = r_abs;
    assign s_emergency  = r_emg_out;

    // Demand flags, registered one cycle behind the queue counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_more <= 1'b0;
            r_s_more <= 1'b0;
            r_p_more <= 1'b0;
            r_l_zero <= 1'b1;
            r_abs    <= 3'b000;
        end else begin
            r_m_more <= ge_margin(w_q[0], w_q[2]);
            r_s_more <= ge_margin(w_q[2], w_q[0]);
            r_p_more <= ge_level(w_q[3], P_THRESH);
            r_l_zero <= (w_q[1] == '0);
            r_abs    <= {ge_level(w_q[0], ABS_THRESH),
                         ge_level(w_q[2], ABS_THRESH),
                         ge_level(w_q[1], ABS_THRESH)};
        end
    end

    // Emergency request synchronizer, FSM state, counter and Moore output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_emg_s1  <= 1'b0;
            r_emg_s2  <= 1'b0;
            r_state   <= E_IDLE;
            r_cnt     <= '0;
            r_emg_out <= 1'b0;
        end else begin
            r_emg_s1  <= emg_req;
            r_emg_s2  <= r_emg_s1;
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_emg_out <= (w_state_nxt == E_ACTIVE) || (w_state_nxt == E_HOLD);
        end
    end

    // Qualify the request for EMG_QUAL cycles, then hold EMG_HOLD cycles past its drop.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            E_IDLE: begin
                if (r_emg_s2) begin
                    w_state_nxt = E_QUAL;
                    w_cnt_nxt   = CW'(1);
                end
            end
            E_QUAL: begin
                if (!r_emg_s2) begin
                    w_state_nxt = E_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CW'(EMG_QUAL)) begin
                    w_state_nxt = E_ACTIVE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            E_ACTIVE: begin
                if (!r_emg_s2) begin
                    w_state_nxt = E_HOLD;
                    w_cnt_nxt   = '0;
                end
            end
            E_HOLD: begin
                if (r_emg_s2) begin
                    w_state_nxt = E_ACTIVE;
                end else if (r_cnt == CW'(EMG_HOLD - 1)) begin
                    w_state_nxt = E_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = E_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_traffic_demand_monitor.sv
// Bench for traffic_demand_monitor: directed scenarios plus a randomized run
// checked against a cycle-stepped reference model built from the lane rules.
module tb_traffic_demand_monitor;

    localparam int DEP_CYCLES  = 4;
    localparam int MORE_MARGIN = 2;
    localparam int ABS_THRESH  = 5;
    localparam int P_THRESH    = 3;
    localparam int EMG_QUAL    = 3;
    localparam int EMG_HOLD    = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       m_det, l_det, s_det, p_btn, emg_req;
    logic [3:0] m_LRYG;
    logic [2:0] s_RYG;
    logic       p;
    logic [2:0] main_num, left_num, sec_num, p_num;
    logic       m_more, s_more, p_more, l_zero;
    logic [2:0] absolute_num;
    logic       s_emergency;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int mq[4];
    bit mp1[4], mp2[4], mp3[4];
    int mrun[4];
    bit me1, me2;
    bit m_act;
    int m_hi, m_lo;
    bit x_mm, x_sm, x_pm, x_lz;
    bit [2:0] x_abs;

    always #5 clk = ~clk;

    traffic_demand_monitor #(
        .DEP_CYCLES(DEP_CYCLES), .MORE_MARGIN(MORE_MARGIN), .ABS_THRESH(ABS_THRESH),
        .P_THRESH(P_THRESH), .EMG_QUAL(EMG_QUAL), .EMG_HOLD(EMG_HOLD)
    ) dut (
        .clk(clk), .rst(rst), .m_det(m_det), .l_det(l_det), .s_det(s_det),
        .p_btn(p_btn), .emg_req(emg_req), .m_LRYG(m_LRYG), .s_RYG(s_RYG), .p(p),
        .main_num(main_num), .left_num(left_num), .sec_num(sec_num), .p_num(p_num),
        .m_more(m_more), .s_more(s_more), .p_more(p_more), .l_zero(l_zero),
        .absolute_num(absolute_num), .s_emergency(s_emergency)
    );

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mq[i] = 0; mp1[i] = 0; mp2[i] = 0; mp3[i] = 0; mrun[i] = 0;
        end
        me1 = 0; me2 = 0; m_act = 0; m_hi = 0; m_lo = 0;
        x_mm = 0; x_sm = 0; x_pm = 0; x_lz = 1; x_abs = 3'b000;
    endtask

    // One clock edge of the behavioural model, using the inputs seen at that edge.
    task automatic model_update();
        bit din[4];
        bit g[4];
        bit arr, tick, r;
        if (rst) begin
            model_reset();
            return;
        end
        din = '{m_det, l_det, s_det, p_btn};
        g   = '{m_LRYG[0], m_LRYG[3], s_RYG[0], p};
        x_mm  = (mq[0] >= mq[2] + MORE_MARGIN);
        x_sm  = (mq[2] >= mq[0] + MORE_MARGIN);
        x_pm  = (mq[3] >= P_THRESH);
        x_lz  = (mq[1] == 0);
        x_abs = {mq[0] >= ABS_THRESH, mq[2] >= ABS_THRESH, mq[1] >= ABS_THRESH};
        for (int i = 0; i < 4; i++) begin
            // input rose two samples ago and was low three samples ago
            arr     = mp2[i] && !mp3[i];
            mrun[i] = g[i] ? mrun[i] + 1 : 0;
            tick    = g[i] && (mrun[i] % DEP_CYCLES == 0);
            if (arr && !tick)      mq[i] = (mq[i] < 7) ? mq[i] + 1 : 7;
            else if (tick && !arr) mq[i] = (mq[i] > 0) ? mq[i] - 1 : 0;
            mp3[i] = mp2[i]; mp2[i] = mp1[i]; mp1[i] = din[i];
        end
        r   = me2;
        me2 = me1;
        me1 = emg_req;
        if (!m_act) begin
            m_hi = r ? m_hi + 1 : 0;
            if (m_hi == EMG_QUAL + 1) begin
                m_act = 1; m_hi = 0; m_lo = 0;
            end
        end else if (r) begin
            m_lo = 0;
        end else begin
            m_lo++;
            if (m_lo == EMG_HOLD + 1) begin
                m_act = 0; m_lo = 0;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic set_det(input int lane, input logic v);
        case (lane)
            0: m_det = v;
            1: l_det = v;
            2: s_det = v;
            default: p_btn = v;
        endcase
    endtask

    task automatic pulses(input int lane, input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) begin
            set_det(lane, 1'b1);
            repeat (hi) cycle();
            set_det(lane, 1'b0);
            repeat (lo) cycle();
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        m_det = 0; l_det = 0; s_det = 0; p_btn = 0; emg_req = 0;
        m_LRYG = 4'b0100; s_RYG = 3'b100; p = 0;
        model_reset();
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if ({main_num, left_num, sec_num, p_num} !== 12'h000) begin
            bad++; $display("FAIL reset_queues: got=%h want=000", {main_num, left_num, sec_num, p_num});
        end
        total++;
        if ({m_more, s_more, p_more, l_zero} !== 4'b0001) begin
            bad++; $display("FAIL reset_flags: got=%b want=0001", {m_more, s_more, p_more, l_zero});
        end
        total++;
        if ({absolute_num, s_emergency} !== 4'b0000) begin
            bad++; $display("FAIL reset_abs_emg: got=%b want=0000", {absolute_num, s_emergency});
        end
    endtask

    task automatic test_main_arrivals();
        pulses(0, 3, 4, 4);
        repeat (2) cycle();
        total++;
        if (main_num !== 3'd3) begin
            bad++; $display("FAIL main_count: got=%0d want=3", main_num);
        end
        total++;
        if ({m_more, s_more, l_zero, absolute_num} !== 6'b101000) begin
            bad++; $display("FAIL main_flags: got=%b want=101000", {m_more, s_more, l_zero, absolute_num});
        end
    endtask

    task automatic test_sec_saturate();
        pulses(2, 9, 3, 3);
        repeat (2) cycle();
        total++;
        if (sec_num !== 3'd7) begin
            bad++; $display("FAIL sec_saturate: got=%0d want=7", sec_num);
        end
        total++;
        if ({absolute_num, s_more, m_more} !== 5'b01010) begin
            bad++; $display("FAIL sec_sat_flags: got=%b want=01010", {absolute_num, s_more, m_more});
        end
    endtask

    task automatic test_departure();
        int want;
        apply_reset();
        pulses(2, 4, 3, 3);
        repeat (3) cycle();
        total++;
        if (sec_num !== 3'd4) begin
            bad++; $display("FAIL dep_preload: got=%0d want=4", sec_num);
        end
        s_RYG = 3'b001;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            want = 4 - k / 4;
            if (want < 0) want = 0;
            total++;
            if (sec_num !== 3'(want)) begin
                bad++; $display("FAIL dep_tick k=%0d: got=%0d want=%0d", k, sec_num, want);
            end
        end
        s_RYG = 3'b100;
    endtask

    task automatic test_collision();
        apply_reset();
        pulses(2, 2, 3, 3);
        repeat (3) cycle();
        s_RYG = 3'b001;
        cycle();
        s_det = 1'b1;
        cycle();
        cycle();
        cycle();
        total++;
        if (sec_num !== 3'd2) begin
            bad++; $display("FAIL collide_same_cycle: got=%0d want=2", sec_num);
        end
        s_det = 1'b0;
        s_RYG = 3'b100;
        repeat (4) cycle();
        total++;
        if (sec_num !== 3'd2) begin
            bad++; $display("FAIL collide_after: got=%0d want=2", sec_num);
        end
    endtask

    task automatic test_emergency();
        apply_reset();
        emg_req = 1'b1;
        repeat (2) cycle();
        emg_req = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            cycle();
            total++;
            if (s_emergency !== 1'b0) begin
                bad++; $display("FAIL emg_short k=%0d: got=%b want=0", k, s_emergency);
            end
        end
        emg_req = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            if (k == 11) emg_req = 1'b0;
            cycle();
            total++;
            if (s_emergency !== ((k >= 6) && (k <= 20))) begin
                bad++; $display("FAIL emg_long k=%0d: got=%b want=%b", k, s_emergency, (k >= 6) && (k <= 20));
            end
        end
        emg_req = 1'b1;
        for (int k = 1; k <= 34; k++) begin
            if (k == 11) emg_req = 1'b0;
            if (k == 15) emg_req = 1'b1;
            if (k == 21) emg_req = 1'b0;
            cycle();
            total++;
            if (s_emergency !== ((k >= 6) && (k <= 30))) begin
                bad++; $display("FAIL emg_reraise k=%0d: got=%b want=%b", k, s_emergency, (k >= 6) && (k <= 30));
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        emg_req = 1'b1;
        pulses(0, 5, 3, 3);
        repeat (2) cycle();
        total++;
        if ({main_num, s_emergency} !== {3'd5, 1'b1}) begin
            bad++; $display("FAIL midrst_pre: got=%0d/%b want=5/1", main_num, s_emergency);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({main_num, left_num, sec_num, p_num, m_more, s_more, p_more, l_zero, absolute_num, s_emergency}
            !== 20'h00010) begin
            bad++; $display("FAIL midrst_outputs: got=%h want=00010",
                {main_num, left_num, sec_num, p_num, m_more, s_more, p_more, l_zero, absolute_num, s_emergency});
        end
        model_reset();
        emg_req = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_random();
        int dcnt[4], gcnt[4], ecnt;
        bit dv[4], gv[4];
        logic [19:0] got, want;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            dcnt[i] = 0; gcnt[i] = 0; dv[i] = 0; gv[i] = 0;
        end
        ecnt = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (dcnt[i] == 0) begin dv[i] = ~dv[i]; dcnt[i] = $urandom_range(2, 6); end
                dcnt[i]--;
                if (gcnt[i] == 0) begin gv[i] = ~gv[i]; gcnt[i] = $urandom_range(1, 20); end
                gcnt[i]--;
                set_det(i, dv[i]);
            end
            if (ecnt == 0) begin emg_req = ~emg_req; ecnt = $urandom_range(1, 16); end
            ecnt--;
            m_LRYG = {gv[1], 2'($urandom_range(0, 3)), gv[0]};
            s_RYG  = {2'($urandom_range(0, 3)), gv[2]};
            p      = gv[3];
            cycle();
            got  = {main_num, left_num, sec_num, p_num, m_more, s_more, p_more, l_zero, absolute_num, s_emergency};
            want = {3'(mq[0]), 3'(mq[1]), 3'(mq[2]), 3'(mq[3]), x_mm, x_sm, x_pm, x_lz, x_abs, m_act};
            total++;
            if (got !== want) begin
                bad++; $display("FAIL random c=%0d: got=%h want=%h", c, got, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_main_arrivals();
        test_sec_saturate();
        test_departure();
        test_collision();
        test_emergency();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
